// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, encodings and types for the execute stage
package ex_stage_pkg;
  localparam int ID_TO_EX_WD = 161;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD = 39;
  localparam int STALL_BUS = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int ALU_ADD = 11;
  localparam int ALU_SUB = 10;
  localparam int ALU_SLT = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND = 7;
  localparam int ALU_NOR = 6;
  localparam int ALU_OR = 5;
  localparam int ALU_XOR = 4;
  localparam int ALU_SLL = 3;
  localparam int ALU_SRL = 2;
  localparam int ALU_SRA = 1;
  localparam int ALU_LUI = 0;
  localparam int SRC1_RS = 2;
  localparam int SRC1_PC = 1;
  localparam int SRC1_SA = 0;
  localparam int SRC2_RT = 3;
  localparam int SRC2_SIMM = 2;
  localparam int SRC2_EIGHT = 1;
  localparam int SRC2_ZIMM = 0;
  localparam logic [1:0] DIV_OP_DIV = 2'b01;
  localparam logic [1:0] DIV_OP_DIVU = 2'b10;
  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [1:0]  div_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } id_ex_t;
endpackage

// File: rtl/ex_stage_div_iter.sv
// div_iter: 32-step restoring divider with sign fix-up and divide-by-zero shortcut
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  div_state_e state_q;
  logic [4:0] cnt_q;
  logic [31:0] q_q, r_q, d_q, a_mag, b_mag, r_dif;
  logic [32:0] r_sh;
  logic qs_q, rs_q, r_ge;
  // Operand magnitudes, one shift-subtract step, and sign-corrected results
  always_comb begin
    a_mag = sgn && a[31] ? -a : a;
    b_mag = sgn && b[31] ? -b : b;
    r_sh = {r_q, q_q[31]};
    r_ge = r_sh >= {1'b0, d_q};
    r_dif = r_sh[31:0] - d_q;
    busy = (state_q == DIV_IDLE && start) || state_q == DIV_BUSY;
    done = state_q == DIV_DONE;
    quotient = done ? (qs_q ? -q_q : q_q) : '0;
    remainder = done ? (rs_q ? -r_q : r_q) : '0;
  end
  // Divider FSM: a zero divisor skips straight to DONE with q=all-ones, r=dividend
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      qs_q <= 1'b0;
      rs_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: if (start) begin
          qs_q <= b != '0 && sgn && (a[31] ^ b[31]);
          rs_q <= b != '0 && sgn && a[31];
          q_q <= b == '0 ? '1 : a_mag;
          r_q <= b == '0 ? a : '0;
          d_q <= b_mag;
          cnt_q <= '0;
          state_q <= b == '0 ? DIV_DONE : DIV_BUSY;
        end
        DIV_BUSY: begin
          q_q <= {q_q[30:0], r_ge};
          r_q <= r_ge ? r_dif : r_sh[31:0];
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= DIV_DONE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: ID/EX register, ALU, memory request generation and iterative divider
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex,
  output logic                    hilo_we,
  output logic [31:0]             hi_wdata,
  output logic [31:0]             lo_wdata
);
  id_ex_t id_ex_q, id_ex_d;
  logic [31:0] src1, src2, imm_s, imm_z, sra_res, ex_result;
  logic ex_is_load, div_start, unused;
  // Next register value: load when EX runs, bubble when EX stops but MEM runs, else hold
  always_comb id_ex_d = stall[2] == NO_STOP ? id_ex_t'(id_to_ex_bus) : stall[3] == STOP ? id_ex_q : id_ex_t'('0);
  // ID/EX pipeline register
  always_ff @(posedge clk) id_ex_q <= rst ? id_ex_t'('0) : id_ex_d;
  // Operand selection, one-hot ALU and bus assembly
  always_comb begin
    imm_s = {{16{id_ex_q.inst[15]}}, id_ex_q.inst[15:0]};
    imm_z = {16'b0, id_ex_q.inst[15:0]};
    src1 = ({32{id_ex_q.sel_src1[SRC1_RS]}} & id_ex_q.rs_data)
         | ({32{id_ex_q.sel_src1[SRC1_PC]}} & id_ex_q.pc)
         | ({32{id_ex_q.sel_src1[SRC1_SA]}} & {27'b0, id_ex_q.inst[10:6]});
    src2 = ({32{id_ex_q.sel_src2[SRC2_RT]}} & id_ex_q.rt_data)
         | ({32{id_ex_q.sel_src2[SRC2_SIMM]}} & imm_s)
         | ({32{id_ex_q.sel_src2[SRC2_EIGHT]}} & 32'd8)
         | ({32{id_ex_q.sel_src2[SRC2_ZIMM]}} & imm_z);
    sra_res = $unsigned($signed(src2) >>> src1[4:0]);
    ex_result = ({32{id_ex_q.alu_op[ALU_ADD]}} & (src1 + src2))
              | ({32{id_ex_q.alu_op[ALU_SUB]}} & (src1 - src2))
              | ({32{id_ex_q.alu_op[ALU_SLT]}} & {31'b0, $signed(src1) < $signed(src2)})
              | ({32{id_ex_q.alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
              | ({32{id_ex_q.alu_op[ALU_AND]}} & (src1 & src2))
              | ({32{id_ex_q.alu_op[ALU_NOR]}} & ~(src1 | src2))
              | ({32{id_ex_q.alu_op[ALU_OR]}} & (src1 | src2))
              | ({32{id_ex_q.alu_op[ALU_XOR]}} & (src1 ^ src2))
              | ({32{id_ex_q.alu_op[ALU_SLL]}} & (src2 << src1[4:0]))
              | ({32{id_ex_q.alu_op[ALU_SRL]}} & (src2 >> src1[4:0]))
              | ({32{id_ex_q.alu_op[ALU_SRA]}} & sra_res)
              | ({32{id_ex_q.alu_op[ALU_LUI]}} & {id_ex_q.inst[15:0], 16'b0});
    ex_is_load = id_ex_q.data_ram_en && id_ex_q.data_ram_wen == 4'b0 && id_ex_q.sel_rf_res;
    div_start = id_ex_q.div_op == DIV_OP_DIV || id_ex_q.div_op == DIV_OP_DIVU;
    ex_to_mem_bus = {id_ex_q.pc, id_ex_q.data_ram_en, id_ex_q.data_ram_wen, id_ex_q.sel_rf_res,
                     id_ex_q.rf_we, id_ex_q.rf_waddr, ex_result};
    ex_to_id_bus = {ex_is_load, id_ex_q.rf_we & ~div_start, id_ex_q.rf_waddr, ex_result};
    data_sram_en = id_ex_q.data_ram_en;
    data_sram_wen = id_ex_q.data_ram_wen;
    data_sram_addr = ex_result;
    data_sram_wdata = id_ex_q.rt_data;
    unused = ^{stall[5:4], stall[1:0], id_ex_q.inst[31:16], id_ex_q.inst[5:0]};
  end
  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .sgn       (id_ex_q.div_op == DIV_OP_DIV),
    .a         (id_ex_q.rs_data),
    .b         (id_ex_q.rt_data),
    .busy      (stallreq_for_ex),
    .done      (hilo_we),
    .quotient  (lo_wdata),
    .remainder (hi_wdata)
  );
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; sits between ID and MEM.
- Registers the ID→EX bus and computes ALU results and load/store addresses.
- Produces the EX→MEM bus plus a forwarding bus back to ID.
- Contains a multi-cycle iterative divider (DIV/DIVU) that holds the pipeline through a stall request and writes HI/LO on completion.

Parameters:
- None. All widths come from shared defines: ID_TO_EX_WD=161, EX_TO_MEM_WD=76, EX_TO_ID_WD=39, StallBus=6.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; bit2=EX register, bit3=MEM register; Stop=1
- id_to_ex_bus  in  161  {pc[32], inst[32], alu_op[12], sel_src1[3], sel_src2[4], data_ram_en, data_ram_wen[4], rf_we, rf_waddr[5], sel_rf_res, div_op[2], rs_data[32], rt_data[32]}
- ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- ex_to_id_bus  out  39  {ex_is_load, rf_we, rf_waddr, ex_result}
- data_sram_en  out  1  data RAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  data RAM address
- data_sram_wdata  out  32  store data
- stallreq_for_ex  out  1  divider busy; requests stall of PC/IF/ID/EX
- hilo_we  out  1  one-cycle HI/LO write strobe
- hi_wdata  out  32  remainder
- lo_wdata  out  32  quotient

Behaviour:
- Pipeline register:
  - rst → clear to 0.
  - stall[2]=1 and stall[3]=0 → load 0 (bubble).
  - stall[2]=0 → load id_to_ex_bus.
  - Otherwise hold.
- ALU:
  - alu_op is one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - All-zero alu_op → result 0.
  - sel_src1 one-hot: rs_data, pc, {27'b0, inst[10:6]}.
  - sel_src2 one-hot: rt_data, sign-ext imm16, 32'd8, zero-ext imm16.
  - Shifts use src1[4:0] as the amount on src2. lui = {imm16, 16'b0}. add/sub wrap, no overflow trap.
- Memory side:
  - data_sram_en = data_ram_en.
  - data_sram_wen = data_ram_wen.
  - data_sram_addr = ALU result.
  - data_sram_wdata = rt_data.
  - ex_is_load = data_ram_en & (data_ram_wen==0) & sel_rf_res.
- Outputs: all bus/SRAM outputs are combinational from the register, so 0 after reset.
- Divider FSM, states IDLE, BUSY, DONE:
  - div_op encoding: 01=DIV (signed), 10=DIVU.
  - IDLE: div_op≠0 and state IDLE → stallreq=1 and latch operands (rs=dividend, rt=divisor).
    - Signed: latch magnitudes, quotient sign = sa^sb, remainder sign = sa.
    - Divisor≠0 → BUSY, count=0.
    - Divisor=0 → DONE with q=32'hFFFF_FFFF, r=dividend, no sign fix-up.
  - BUSY: one restoring shift-subtract step per cycle, stallreq=1. Go to DONE after count=31 (32 steps).
  - DONE: stallreq=0, hilo_we=1 with sign-corrected q→lo, r→hi. Next cycle → IDLE.
  - The register advances on the same edge, so the division does not retrigger.
  - Latency: 34 EX cycles normal (1 IDLE + 32 BUSY + 1 DONE); 2 cycles for divide-by-zero.
  - 0x8000_0000 / -1 (DIV) → lo=0x8000_0000, hi=0 (two's-complement wrap).
  - hilo_we=0, hi/lo_wdata=0 outside DONE.
- Reset mid-division: state→IDLE, count=0, stallreq=0, no hilo_we.
- Forwarding: ex_to_id_bus reflects the current register every cycle, including during stall. For a div instruction, rf_we is forced 0.

Decomposition:
- Shared defines header holds: bus widths, StallBus, Stop/NoStop, ALU op bit indices, div_op encodings, FSM state codes.
- One sub-module: div_iter (start, signed, a, b → busy, done, quotient, remainder), containing the FSM.
- The ALU stays inline.

Test Plan:
- add: rs=5, rt=7 → ex_result=12, rf_we=1, waddr passed, ex_is_load=0.
- sw: rs=0x1000, imm=4, rt=0xDEAD_BEEF → data_sram_addr=0x1004, wen=4'hF, wdata=0xDEAD_BEEF.
- DIV -8/3 → stallreq high for exactly 33 cycles, then hilo_we=1 with lo=0xFFFF_FFFE, hi=0xFFFF_FFFE. DIVU 100/7 → lo=14, hi=2.
- DIV by 0 with dividend 9 → stallreq for 1 cycle, then lo=0xFFFF_FFFF, hi=9. Also check DIV 0x8000_0000/-1 → lo=0x8000_0000, hi=0.
- Stall bubble: stall=6'b000111 → next ex_to_mem_bus=0. stall=6'b001111 → register held unchanged.
- Assert rst during BUSY at cycle 10 → next cycle stallreq=0, hilo_we=0, all outputs 0. A new div after reset completes normally.
